// File: rtl/button_pkg.sv
// Shared types and bit positions for the push-button MMIO peripheral.
// Holds the per-key debounce state encoding and the status word field offsets.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_PEND = 2'd1,
    PRESSED    = 2'd2,
    REL_PEND   = 2'd3
  } btn_state_t;

  localparam int LEVEL_LSB  = 0;
  localparam int STICKY_LSB = 8;

endpackage

// File: rtl/debounce_channel.sv
// One key: 2-flop synchroniser, debounce FSM and stability counter.
// Ports: clk, rst_n, raw (async pin) -> level (debounced), rise (1-cycle press).
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic REL_LVL = ACTIVE_LOW;

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic act;

  // Flops keep pin polarity so they reset to the released pin level;
  // the polarity flip after them is equivalent to flipping before.
  assign sync1_d = raw;
  assign sync2_d = sync1_q;
  assign act     = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (act) begin
          state_d = PRESS_PEND;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_PEND: begin
        if (!act) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          rise    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!act) begin
          state_d = REL_PEND;
          cnt_d   = CNT_ONE;
        end
      end
      REL_PEND: begin
        if (act) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = (state_q == PRESSED) || (state_q == REL_PEND);

endmodule

// File: rtl/button_mmio.sv
// Push-button status word: debounced levels plus read-to-clear press flags.
// Ports: clk, rst_n, buttons_raw, rd_en -> button_read; irq if BUTTON_MMIO_IRQ_EN.
module button_mmio
  import button_pkg::*;
#(
  parameter int N               = 32,
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  input  logic                   rd_en,
  output logic [N-1:0]           button_read
`ifdef BUTTON_MMIO_IRQ_EN
  ,
  output logic                   irq
`endif
);

  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] sticky_q, sticky_d;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (buttons_raw[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  // A press landing on the clearing read was not in the word the CPU saw,
  // so the set term overrides the clear.
  always_comb begin
    sticky_d = rise | (sticky_q & ~{NUM_BUTTONS{rd_en}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    button_read = '0;
    button_read[LEVEL_LSB +: NUM_BUTTONS]  = level;
    button_read[STICKY_LSB +: NUM_BUTTONS] = sticky_q;
  end

`ifdef BUTTON_MMIO_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = |sticky_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_button_mmio.sv
// Directed bench for button_mmio with DEBOUNCE_CYCLES=4, active-low keys.
// Covers reset, press/release latency, glitch, read-clear, collision, irq.
module tb_button_mmio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [3:0]  buttons_raw;
  logic [31:0] button_read;
`ifdef BUTTON_MMIO_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_mmio #(
    .N              (32),
    .NUM_BUTTONS    (4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .buttons_raw(buttons_raw),
    .rd_en      (rd_en),
    .button_read(button_read)
`ifdef BUTTON_MMIO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    rd_en       = 1'b0;
    buttons_raw = 4'hF;
    #7;
    chk("rst_hold", button_read, 32'h0);
`ifdef BUTTON_MMIO_IRQ_EN
    chk("rst_irq", {31'b0, irq}, 32'h0);
`endif
    tick(2);
    chk("rst_hold2", button_read, 32'h0);
    rst_n = 1'b1;
    tick(10);
    chk("idle", button_read, 32'h0);

    // clean press / release on key0
    buttons_raw[0] = 1'b0;
    tick(5);
    chk("press_early", button_read, 32'h0);
    tick(1);
    chk("press", button_read, 32'h101);
    buttons_raw[0] = 1'b1;
    tick(5);
    chk("rel_early", button_read, 32'h101);
    tick(1);
    chk("rel", button_read, 32'h100);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("clr_rel", button_read, 32'h0);

    // 3-cycle glitch on key2
    buttons_raw[2] = 1'b0;
    tick(3);
    buttons_raw[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch", button_read, 32'h0);
    end

    // read-clear with key held
    buttons_raw[0] = 1'b0;
    tick(6);
    chk("press2", button_read, 32'h101);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("rdclr", button_read, 32'h1);
    tick(1);
    chk("rdclr_hold", button_read, 32'h1);

    // re-arm key0 flag
    buttons_raw[0] = 1'b1;
    tick(6);
    chk("rel2", button_read, 32'h0);
    buttons_raw[0] = 1'b0;
    tick(6);
    chk("press3", button_read, 32'h101);

    // key1 rise on the same edge as the clearing read
    buttons_raw[1] = 1'b0;
    tick(5);
    chk("coll_pre", button_read, 32'h101);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("coll", button_read, 32'h203);
    tick(1);
    chk("coll_keep", button_read, 32'h203);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("coll_clr", button_read, 32'h3);

    // async reset mid-debounce of key3, keys 0/1 still held
    buttons_raw[3] = 1'b0;
    tick(3);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst", button_read, 32'h0);
    buttons_raw[3] = 1'b1;
    tick(1);
    chk("rst_low", button_read, 32'h0);
    rst_n = 1'b1;
    tick(5);
    chk("re_early", button_read, 32'h0);
    tick(1);
    chk("re_press", button_read, 32'h303);
    tick(4);
    chk("no_key3", button_read, 32'h303);

`ifdef BUTTON_MMIO_IRQ_EN
    chk("irq_on", {31'b0, irq}, 32'h1);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("irq_rd_word", button_read, 32'h3);
    chk("irq_lag", {31'b0, irq}, 32'h1);
    tick(1);
    chk("irq_off", {31'b0, irq}, 32'h0);
    buttons_raw[3] = 1'b0;
    tick(6);
    chk("k3_word", button_read, 32'h80B);
    chk("k3_irq_lo", {31'b0, irq}, 32'h0);
    tick(1);
    chk("k3_irq_hi", {31'b0, irq}, 32'h1);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("k3_irq_lag", {31'b0, irq}, 32'h1);
    tick(1);
    chk("k3_irq_off", {31'b0, irq}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
